level_peak_hold: RTL and testbench
==================================

LEVEL_PEAK_HOLD -- requirements
Module: level_peak_hold

Interface
REQ-001 Parameter width, default 16: bit width of input min/max values and of output level/peak; legal range 4..32.
REQ-002 Parameter hold_count, default 32: number of updates a new peak is held before it falls; legal range 1..65535.
REQ-003 Parameter decay_shift, default 4: level decay per update = level >> decay_shift, with a minimum step of 1; legal range 1..width-1.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-006 i_valid  input  1  upstream min/max pair valid.
REQ-007 i_ready  output  1  block can accept a pair; combinational, high only in IDLE.
REQ-008 i_min_value  input  width  section minimum, signed two's complement.
REQ-009 i_max_value  input  width  section maximum, signed two's complement.
REQ-010 o_valid  output  1  o_level/o_peak valid; registered.
REQ-011 o_ready  input  1  downstream accepts the output.
REQ-012 o_level  output  width  decaying level, unsigned; registered.
REQ-013 o_peak  output  width  peak-hold value, unsigned; registered.

Function
REQ-014 The block SHALL implement three states: IDLE, UPDATE, OUT.
REQ-015 IDLE: i_ready=1; on a rising edge with i_valid=1, amp is captured and the state goes to UPDATE; otherwise the state stays IDLE.
REQ-016 amp SHALL be the larger of |i_min_value| and |i_max_value|, computed as unsigned width bits; |-2^(width-1)| = 2^(width-1), with no saturation and no overflow.
REQ-017 UPDATE (exactly one cycle): level, peak and hold counter are updated per REQ-018..REQ-020; o_valid<=1; next state OUT.
REQ-018 Level update: if amp >= level then level<=amp; else level <= max(amp, level - max(1, level >> decay_shift)).
REQ-019 Peak update, if amp >= peak: peak<=amp and hold<=hold_count.
REQ-020 Peak update, otherwise: if hold != 0 then hold<=hold-1 and peak is unchanged; if hold == 0 then peak<=(new level value from REQ-018).
REQ-021 Invariant: o_peak >= o_level after every update.
REQ-022 OUT: o_valid=1; o_level, o_peak and all state are stable until o_ready=1; on an edge with o_ready=1, o_valid<=0 and the state goes to IDLE.
REQ-023 Latency: with acceptance at edge E, o_valid is high after edge E+1; with o_ready tied high, pairs are accepted at most once every 3 cycles.
REQ-024 i_valid is ignored outside IDLE; no input is lost, because i_ready=0 outside IDLE.
REQ-025 o_level and o_peak change only in UPDATE and never change while o_valid=1.

Reset
REQ-026 A reset at any edge, including mid-operation, SHALL force: state=IDLE, o_valid=0, level=0, peak=0, hold=0, amp=0, o_level=0, o_peak=0.
REQ-027 Reset SHALL take priority over every other event in the same cycle; a pair presented in that cycle is not accepted.

Verification
(width=16, hold_count=4, decay_shift=2)
REQ-028 Reset with i_valid=1 -> o_valid=0, o_level=0, o_peak=0; after reset is released, i_ready=1 in IDLE.
REQ-029 Pair min=-100, max=50, o_ready=1 -> o_valid high after edge E+1, o_level=100, o_peak=100; then pair min=max=0 -> o_level=75, o_peak=100.
REQ-030 Pair min=0x8000, max=0x0000 -> o_level=0x8000, o_peak=0x8000, with no wrap to 0.
REQ-031 Peak hold: after peak=100, send zero pairs -> peak stays 100 for 4 updates; on the 5th zero update, o_peak equals that update's o_level.
REQ-032 Decay floor: from level=3 with zero pairs -> o_level sequence 2, 1, 0, 0.
REQ-033 Backpressure: o_ready=0 for 10 cycles while in OUT -> o_valid=1, i_ready=0, outputs stable; on the edge where o_ready=1, o_valid falls and the next cycle shows i_ready=1.

Source files
------------

// File: rtl/level_peak_hold.sv
// level_peak_hold: turns a stream of signed section min/max pairs into a
// decaying level meter value and a peak-hold value.
//
// Handshake (both sides): a transfer happens on a rising edge where valid
// and ready are both high. The input side is ready only in IDLE. Once
// o_valid rises it stays high, with o_level/o_peak frozen, until the edge
// where o_ready is high.
module level_peak_hold #(
    parameter int width       = 16,
    parameter int hold_count  = 32,
    parameter int decay_shift = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_valid,
    output logic             i_ready,
    input  logic [width-1:0] i_min_value,
    input  logic [width-1:0] i_max_value,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [width-1:0] o_level,
    output logic [width-1:0] o_peak,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPDATE = 2'd1,
        OUT    = 2'd2
    } state_t;

    localparam logic [width-1:0] one       = width'(1);
    localparam logic [15:0]      hold_init = 16'(hold_count);

    state_t           state;
    state_t           state_next;
    logic [width-1:0] abs_min;
    logic [width-1:0] abs_max;
    logic [width-1:0] amp_in;
    logic [width-1:0] amp;
    logic [width-1:0] level;
    logic [width-1:0] peak;
    logic [15:0]      hold;
    logic [width-1:0] decay;
    logic [width-1:0] step;
    logic [width-1:0] lowered;
    logic [width-1:0] level_next;

    // Magnitude of each input taken as an unsigned value so that the most
    // negative code maps to 2^(width-1) instead of wrapping.
    always_comb begin
        abs_min = i_min_value[width-1] ? (-i_min_value) : i_min_value;
        abs_max = i_max_value[width-1] ? (-i_max_value) : i_max_value;
        amp_in  = (abs_min > abs_max) ? abs_min : abs_max;
    end

    // New level: jump up to amp, or fall by level>>decay_shift (at least 1)
    // without dropping below amp. level > amp >= 0 on the falling path, so
    // level - step cannot underflow.
    always_comb begin
        decay   = level >> decay_shift;
        step    = (decay == '0) ? one : decay;
        lowered = level - step;
        if (amp >= level) begin
            level_next = amp;
        end else if (lowered > amp) begin
            level_next = lowered;
        end else begin
            level_next = amp;
        end
    end

    // Next-state logic; input ready is a pure decode of IDLE.
    always_comb begin
        state_next = state;
        i_ready    = 1'b0;
        case (state)
            IDLE: begin
                i_ready = 1'b1;
                if (i_valid) begin
                    state_next = UPDATE;
                end
            end
            UPDATE: begin
                state_next = OUT;
            end
            OUT: begin
                if (o_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath registers: capture amp in IDLE, update meters in UPDATE,
    // release the output in OUT.
    always_ff @(posedge clk) begin
        if (reset) begin
            amp     <= '0;
            level   <= '0;
            peak    <= '0;
            hold    <= '0;
            o_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        amp <= amp_in;
                    end
                end
                UPDATE: begin
                    level   <= level_next;
                    o_valid <= 1'b1;
                    if (amp >= peak) begin
                        peak <= amp;
                        hold <= hold_init;
                    end else if (hold != 16'd0) begin
                        hold <= hold - 16'd1;
                    end else begin
                        peak <= level_next;
                    end
                end
                OUT: begin
                    if (o_ready) begin
                        o_valid <= 1'b0;
                    end
                end
                default: begin
                    o_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_level   = level;
    assign o_peak    = peak;
    assign dbg_state = state;

endmodule

// File: tb/tb_level_peak_hold.sv
// Directed bench for level_peak_hold (width=16, hold_count=4, decay_shift=2).
module tb_level_peak_hold;

    localparam int W      = 16;
    localparam int HOLD_N = 4;
    localparam int DSHIFT = 2;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_UPDATE = 2'd1;
    localparam logic [1:0] ST_OUT    = 2'd2;

    logic         clk;
    logic         reset;
    logic         i_valid;
    logic         i_ready;
    logic [W-1:0] i_min_value;
    logic [W-1:0] i_max_value;
    logic         o_valid;
    logic         o_ready;
    logic [W-1:0] o_level;
    logic [W-1:0] o_peak;
    logic [1:0]   dbg_state;

    int n_checks;
    int n_pass;

    // Reference meter state kept by the bench.
    int m_level;
    int m_peak;
    int m_hold;

    logic [2*W-1:0] exp_q[$];

    level_peak_hold #(
        .width(W),
        .hold_count(HOLD_N),
        .decay_shift(DSHIFT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .i_valid(i_valid),
        .i_ready(i_ready),
        .i_min_value(i_min_value),
        .i_max_value(i_max_value),
        .o_valid(o_valid),
        .o_ready(o_ready),
        .o_level(o_level),
        .o_peak(o_peak),
        .dbg_state(dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    endtask

    task automatic model_reset();
        m_level = 0;
        m_peak  = 0;
        m_hold  = 0;
    endtask

    // Meter update written straight from the behavioural description, in
    // plain integer arithmetic.
    task automatic model_push(input logic [W-1:0] mn, input logic [W-1:0] mx);
        int a_min;
        int a_max;
        int amp;
        int step;
        int nl;
        a_min = int'($signed(mn));
        a_max = int'($signed(mx));
        if (a_min < 0) a_min = -a_min;
        if (a_max < 0) a_max = -a_max;
        amp = (a_min > a_max) ? a_min : a_max;
        if (amp >= m_level) begin
            nl = amp;
        end else begin
            step = m_level / (1 << DSHIFT);
            if (step < 1) step = 1;
            nl = m_level - step;
            if (nl < amp) nl = amp;
        end
        if (amp >= m_peak) begin
            m_peak = amp;
            m_hold = HOLD_N;
        end else if (m_hold != 0) begin
            m_hold = m_hold - 1;
        end else begin
            m_peak = nl;
        end
        m_level = nl;
        exp_q.push_back({W'(m_level), W'(m_peak)});
    endtask

    // Driver: present one pair (called at posedge+1), follow it through
    // UPDATE to OUT, score it, and with o_ready high see it drain to IDLE.
    task automatic send_pair(input string tag, input logic [W-1:0] mn, input logic [W-1:0] mx,
                             output logic [W-1:0] obs_level, output logic [W-1:0] obs_peak);
        logic [2*W-1:0] e;
        i_valid     = 1'b1;
        i_min_value = mn;
        i_max_value = mx;
        check({tag, " i_ready"}, 32'(i_ready), 32'd1);
        model_push(mn, mx);
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        check({tag, " o_valid_low_in_update"}, 32'(o_valid), 32'd0);
        check({tag, " state_update"}, 32'(dbg_state), 32'(ST_UPDATE));
        @(posedge clk);
        #1;
        check({tag, " o_valid_latency"}, 32'(o_valid), 32'd1);
        obs_level = o_level;
        obs_peak  = o_peak;
        if (exp_q.size() == 0) begin
            check({tag, " scoreboard_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check({tag, " level"}, 32'(o_level), 32'(e[2*W-1:W]));
            check({tag, " peak"}, 32'(o_peak), 32'(e[W-1:0]));
            check({tag, " peak_ge_level"}, 32'(o_peak >= o_level), 32'd1);
        end
        if (o_ready) begin
            @(posedge clk);
            #1;
            check({tag, " o_valid_drop"}, 32'(o_valid), 32'd0);
            check({tag, " i_ready_back"}, 32'(i_ready), 32'd1);
        end
    endtask

    logic [W-1:0] lv;
    logic [W-1:0] pk;
    logic [W-1:0] hold_level;
    logic [W-1:0] hold_peak;
    bit           seen;

    // Directed sequence
    initial begin
        n_checks    = 0;
        n_pass      = 0;
        reset       = 1'b1;
        i_valid     = 1'b1;
        i_min_value = 16'h1234;
        i_max_value = 16'h0100;
        o_ready     = 1'b1;
        model_reset();

        // Reset with a pair presented: nothing is accepted.
        repeat (3) @(posedge clk);
        #1;
        check("rst o_valid", 32'(o_valid), 32'd0);
        check("rst o_level", 32'(o_level), 32'd0);
        check("rst o_peak", 32'(o_peak), 32'd0);
        check("rst state", 32'(dbg_state), 32'(ST_IDLE));
        reset   = 1'b0;
        i_valid = 1'b0;
        check("post_rst i_ready", 32'(i_ready), 32'd1);

        // Basic pair and first decay step.
        send_pair("p1", 16'(-100), 16'd50, lv, pk);
        check("p1 level100", 32'(lv), 32'd100);
        check("p1 peak100", 32'(pk), 32'd100);
        send_pair("z1", 16'd0, 16'd0, lv, pk);
        check("z1 level75", 32'(lv), 32'd75);
        check("z1 peak100", 32'(pk), 32'd100);

        // Peak hold: four zero updates in total keep 100, the fifth falls.
        for (int i = 2; i <= 4; i++) begin
            send_pair($sformatf("z%0d", i), 16'd0, 16'd0, lv, pk);
            check($sformatf("z%0d peak_held", i), 32'(pk), 32'd100);
        end
        send_pair("z5", 16'd0, 16'd0, lv, pk);
        check("z5 peak_eq_level", 32'(pk), 32'(lv));
        check("z5 level25", 32'(lv), 32'd25);

        // Most negative code: magnitude 0x8000 with no wrap.
        send_pair("neg_max", 16'h8000, 16'h0000, lv, pk);
        check("neg_max level", 32'(lv), 32'h8000);
        check("neg_max peak", 32'(pk), 32'h8000);

        // A few random pairs scored by the model only.
        for (int i = 0; i < 6; i++) begin
            send_pair($sformatf("rnd%0d", i), 16'($urandom_range(0, 65535)),
                      16'($urandom_range(0, 65535)), lv, pk);
        end

        // Reset mid-operation (in UPDATE) with a pair presented.
        i_valid     = 1'b1;
        i_min_value = 16'd7;
        i_max_value = 16'd9;
        @(posedge clk);
        #1;
        check("mid_rst accepted", 32'(dbg_state), 32'(ST_UPDATE));
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst state", 32'(dbg_state), 32'(ST_IDLE));
        check("mid_rst o_valid", 32'(o_valid), 32'd0);
        check("mid_rst o_level", 32'(o_level), 32'd0);
        check("mid_rst o_peak", 32'(o_peak), 32'd0);
        reset   = 1'b0;
        i_valid = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check("mid_rst no_accept", 32'(dbg_state), 32'(ST_IDLE));

        // Decay floor from level 3.
        send_pair("floor_seed", 16'd3, 16'd0, lv, pk);
        check("floor_seed level3", 32'(lv), 32'd3);
        send_pair("floor1", 16'd0, 16'd0, lv, pk);
        check("floor1 level2", 32'(lv), 32'd2);
        send_pair("floor2", 16'd0, 16'd0, lv, pk);
        check("floor2 level1", 32'(lv), 32'd1);
        send_pair("floor3", 16'd0, 16'd0, lv, pk);
        check("floor3 level0", 32'(lv), 32'd0);
        send_pair("floor4", 16'd0, 16'd0, lv, pk);
        check("floor4 level0", 32'(lv), 32'd0);

        // Backpressure: hold OUT for 10 cycles, with an ignored pair offered.
        o_ready = 1'b0;
        send_pair("bp", 16'd500, 16'(-20), hold_level, hold_peak);
        i_valid     = 1'b1;
        i_min_value = 16'd1000;
        i_max_value = 16'd1000;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("bp%0d o_valid", i), 32'(o_valid), 32'd1);
            check($sformatf("bp%0d i_ready", i), 32'(i_ready), 32'd0);
            check($sformatf("bp%0d level_stable", i), 32'(o_level), 32'(hold_level));
            check($sformatf("bp%0d peak_stable", i), 32'(o_peak), 32'(hold_peak));
        end
        i_valid = 1'b0;
        o_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp release o_valid", 32'(o_valid), 32'd0);
        check("bp release i_ready", 32'(i_ready), 32'd1);

        // Bounded wait to confirm no stray output appears afterwards.
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (o_valid) seen = 1'b1;
        end
        check("idle no_output", 32'(seen), 32'd0);
        check("scoreboard drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
